bp_me_cfg_responder: RTL and testbench

// - Responder end of the IO cfg command protocol driven by the mmio cfg loader: accepts

---
 rtl/bp_me_cfg_responder.sv | 132 +++++++++++++
 tb/tb_bp_me_cfg_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bp_me_cfg_responder.sv
// Responder for IO cfg commands: small cfg register file plus a CCE instruction-RAM window.
// Handles one command at a time and returns one response per accepted command.
module bp_me_cfg_responder #(
  parameter int paddr_width_p   = 40,
  parameter int data_width_p    = 64,
  parameter int core_id_width_p = 4,
  parameter int inst_width_p    = 64,
  parameter int inst_ram_els_p  = 256,
  parameter logic [paddr_width_p-1:0] inst_base_p = 'h8000
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              io_cmd_v_i,
  output logic                              io_cmd_yumi_o,
  input  logic                              io_cmd_type_i,
  input  logic [paddr_width_p-1:0]          io_cmd_addr_i,
  input  logic [1:0]                        io_cmd_size_i,
  input  logic [data_width_p-1:0]           io_cmd_data_i,
  output logic                              io_resp_v_o,
  input  logic                              io_resp_ready_i,
  output logic                              io_resp_type_o,
  output logic [paddr_width_p-1:0]          io_resp_addr_o,
  output logic [1:0]                        io_resp_size_o,
  output logic [data_width_p-1:0]           io_resp_data_o,
  output logic                              freeze_o,
  output logic [core_id_width_p-1:0]        core_id_o,
  output logic                              cce_mode_o,
  output logic                              err_o,
  output logic                              inst_w_v_o,
  output logic                              inst_r_v_o,
  output logic [$clog2(inst_ram_els_p)-1:0] inst_addr_o,
  output logic [inst_width_p-1:0]           inst_data_o,
  input  logic [inst_width_p-1:0]           inst_data_i
);

  localparam int idx_w = $clog2(inst_ram_els_p);
  localparam logic [paddr_width_p-1:0] ram_end = inst_base_p + paddr_width_p'(8 * inst_ram_els_p);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RAM_WAIT = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;

  function automatic logic [data_width_p-1:0] size_mask(input logic [1:0] size);
    logic [data_width_p-1:0] m;
    m = '1;
    case (size)
      2'd0:    m = data_width_p'(8'hFF);
      2'd1:    m = data_width_p'(16'hFFFF);
      2'd2:    m = data_width_p'(32'hFFFF_FFFF);
      default: m = '1;
    endcase
    return m;
  endfunction

  logic [1:0]               state;
  logic                     accept;
  logic                     ram_hit, hit_freeze, hit_core, hit_mode, mapped;
  logic [paddr_width_p-1:0] ram_off;
  logic [data_width_p-1:0]  wdata, reg_rdata;

  // Reset gates the handshake so nothing is consumed while the block is held in reset.
  assign accept        = (state == IDLE) & io_cmd_v_i & reset_n_i;
  assign io_cmd_yumi_o = accept;
  assign io_resp_v_o   = (state == RESP);

  assign ram_hit    = (io_cmd_addr_i >= inst_base_p) && (io_cmd_addr_i < ram_end);
  assign ram_off    = io_cmd_addr_i - inst_base_p;
  assign hit_freeze = (io_cmd_addr_i == paddr_width_p'('h0));
  assign hit_core   = (io_cmd_addr_i == paddr_width_p'('h8));
  assign hit_mode   = (io_cmd_addr_i == paddr_width_p'('h10));
  assign mapped     = ram_hit | hit_freeze | hit_core | hit_mode;
  assign wdata      = io_cmd_data_i & size_mask(io_cmd_size_i);

  always_comb begin
    reg_rdata = '0;
    if (hit_freeze)    reg_rdata = data_width_p'(freeze_o);
    else if (hit_core) reg_rdata = data_width_p'(core_id_o);
    else if (hit_mode) reg_rdata = data_width_p'(cce_mode_o);
  end

  assign inst_w_v_o  = accept & io_cmd_type_i & ram_hit;
  assign inst_r_v_o  = accept & ~io_cmd_type_i & ram_hit;
  assign inst_addr_o = idx_w'(ram_off >> 3);
  assign inst_data_o = inst_width_p'(wdata);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      freeze_o       <= 1'b1;
      core_id_o      <= '0;
      cce_mode_o     <= 1'b0;
      err_o          <= 1'b0;
      io_resp_type_o <= 1'b0;
      io_resp_addr_o <= '0;
      io_resp_size_o <= '0;
      io_resp_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            io_resp_type_o <= io_cmd_type_i;
            io_resp_addr_o <= io_cmd_addr_i;
            io_resp_size_o <= io_cmd_size_i;
            if (!mapped) err_o <= 1'b1;
            if (io_cmd_type_i) begin
              io_resp_data_o <= '0;
              if (hit_freeze) freeze_o   <= wdata[0];
              if (hit_core)   core_id_o  <= wdata[core_id_width_p-1:0];
              if (hit_mode)   cce_mode_o <= wdata[0];
              state <= RESP;
            end else if (ram_hit) begin
              state <= RAM_WAIT;
            end else begin
              io_resp_data_o <= reg_rdata & size_mask(io_cmd_size_i);
              state <= RESP;
            end
          end
        end
        // RAM read data arrives exactly one cycle after the read strobe.
        RAM_WAIT: begin
          io_resp_data_o <= data_width_p'(inst_data_i) & size_mask(io_resp_size_o);
          state <= RESP;
        end
        RESP: begin
          if (io_resp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_cfg_responder.sv
// Directed bench for bp_me_cfg_responder with a response scoreboard and decoupled monitor.
module tb_bp_me_cfg_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_cmd_v, io_cmd_yumi, io_cmd_type;
  logic [39:0] io_cmd_addr;
  logic [1:0]  io_cmd_size;
  logic [63:0] io_cmd_data;
  logic        io_resp_v, io_resp_ready, io_resp_type;
  logic [39:0] io_resp_addr;
  logic [1:0]  io_resp_size;
  logic [63:0] io_resp_data;
  logic        freeze, cce_mode, err;
  logic [3:0]  core_id;
  logic        inst_w_v, inst_r_v;
  logic [7:0]  inst_addr;
  logic [63:0] inst_wdata, inst_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        t;
    logic [39:0] a;
    logic [1:0]  s;
    logic [63:0] d;
  } resp_t;
  resp_t exp_q[$];

  logic [63:0] mem [256];

  always #5 clk = ~clk;

  bp_me_cfg_responder dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .io_cmd_v_i(io_cmd_v), .io_cmd_yumi_o(io_cmd_yumi), .io_cmd_type_i(io_cmd_type),
    .io_cmd_addr_i(io_cmd_addr), .io_cmd_size_i(io_cmd_size), .io_cmd_data_i(io_cmd_data),
    .io_resp_v_o(io_resp_v), .io_resp_ready_i(io_resp_ready), .io_resp_type_o(io_resp_type),
    .io_resp_addr_o(io_resp_addr), .io_resp_size_o(io_resp_size), .io_resp_data_o(io_resp_data),
    .freeze_o(freeze), .core_id_o(core_id), .cce_mode_o(cce_mode), .err_o(err),
    .inst_w_v_o(inst_w_v), .inst_r_v_o(inst_r_v), .inst_addr_o(inst_addr),
    .inst_data_o(inst_wdata), .inst_data_i(inst_rdata)
  );

  // Instruction RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (inst_w_v) mem[inst_addr] <= inst_wdata;
    if (inst_r_v) inst_rdata <= mem[inst_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && io_resp_v && io_resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got addr 0x%0h with empty scoreboard", io_resp_addr);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("resp_type", 64'(io_resp_type), 64'(e.t));
          chk("resp_addr", 64'(io_resp_addr), 64'(e.a));
          chk("resp_size", 64'(io_resp_size), 64'(e.s));
          chk("resp_data", io_resp_data, e.d);
        end
      end
    end
  end

  // Presents a command and returns at the negedge of the accepting cycle.
  task automatic issue(input logic t, input logic [39:0] a, input logic [1:0] s, input logic [63:0] d);
    int n;
    io_cmd_v = 1'b1; io_cmd_type = t; io_cmd_addr = a; io_cmd_size = s; io_cmd_data = d;
    n = 0;
    @(negedge clk);
    while (!io_cmd_yumi && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!io_cmd_yumi) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: yumi 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic xact(input logic t, input logic [39:0] a, input logic [1:0] s, input logic [63:0] d,
                      input logic [63:0] exp, input int lat, input logic ew, input logic er,
                      input logic [7:0] eidx);
    exp_q.push_back('{t, a, s, exp});
    issue(t, a, s, d);
    chk("inst_w_v", 64'(inst_w_v), 64'(ew));
    chk("inst_r_v", 64'(inst_r_v), 64'(er));
    if (ew || er) chk("inst_addr", 64'(inst_addr), 64'(eidx));
    if (ew) chk("inst_wdata", inst_wdata, d);
    @(posedge clk); #1 io_cmd_v = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("resp_v_latency", 64'(io_resp_v), 64'(i == lat));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; io_cmd_v = 1'b0; io_cmd_type = 1'b0; io_cmd_addr = '0;
    io_cmd_size = '0; io_cmd_data = '0; io_resp_ready = 1'b1; inst_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_freeze", 64'(freeze), 64'd1);
    chk("rst_core_id", 64'(core_id), 64'd0);
    chk("rst_resp_v", 64'(io_resp_v), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;

    // Register write/read of core_id.
    xact(1'b1, 40'h8, 2'd3, 64'hFFFF_FFFF_FFFF_FFF3, 64'd0, 1, 1'b0, 1'b0, 8'd0);
    chk("core_id", 64'(core_id), 64'h3);
    xact(1'b0, 40'h8, 2'd3, 64'd0, 64'h3, 1, 1'b0, 1'b0, 8'd0);

    // Instruction RAM write then reads at full and half-word size.
    xact(1'b1, 40'h8018, 2'd3, 64'hDEAD_BEEF_0123_4567, 64'd0, 1, 1'b1, 1'b0, 8'd3);
    xact(1'b0, 40'h8018, 2'd3, 64'd0, 64'hDEAD_BEEF_0123_4567, 2, 1'b0, 1'b1, 8'd3);
    xact(1'b0, 40'h8018, 2'd1, 64'd0, 64'h4567, 2, 1'b0, 1'b1, 8'd3);
    xact(1'b1, 40'h87F8, 2'd3, 64'h0000_1111_2222_3333, 64'd0, 1, 1'b1, 1'b0, 8'd255);
    chk("err_after_good", 64'(err), 64'd0);

    // Backpressure: response held while the next command waits.
    exp_q.push_back('{1'b1, 40'h10, 2'd3, 64'd0});
    issue(1'b1, 40'h10, 2'd3, 64'h1);
    @(posedge clk);
    #1 io_resp_ready = 1'b0;
    io_cmd_v = 1'b1; io_cmd_type = 1'b0; io_cmd_addr = 40'h10; io_cmd_size = 2'd0; io_cmd_data = '0;
    exp_q.push_back('{1'b0, 40'h10, 2'd0, 64'h1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_v", 64'(io_resp_v), 64'd1);
      chk("bp_resp_addr", 64'(io_resp_addr), 64'h10);
      chk("bp_resp_type", 64'(io_resp_type), 64'd1);
      chk("bp_yumi", 64'(io_cmd_yumi), 64'd0);
    end
    chk("cce_mode", 64'(cce_mode), 64'd1);
    @(posedge clk); #1 io_resp_ready = 1'b1;
    @(negedge clk);
    chk("hs_yumi", 64'(io_cmd_yumi), 64'd0);
    @(negedge clk);
    chk("next_accept", 64'(io_cmd_yumi), 64'd1);
    @(posedge clk); #1 io_cmd_v = 1'b0;
    @(negedge clk);
    chk("next_resp_v", 64'(io_resp_v), 64'd1);
    @(posedge clk); #1;

    // Unmapped read sets sticky error.
    xact(1'b0, 40'h40, 2'd3, 64'd0, 64'd0, 1, 1'b0, 1'b0, 8'd0);
    chk("err_set", 64'(err), 64'd1);
    xact(1'b0, 40'h8, 2'd3, 64'd0, 64'h3, 1, 1'b0, 1'b0, 8'd0);
    chk("err_sticky", 64'(err), 64'd1);

    // Byte-masked freeze write, then reset while the response is pending.
    io_resp_ready = 1'b0;
    issue(1'b1, 40'h0, 2'd0, 64'h100);
    @(posedge clk); #1 io_cmd_v = 1'b0;
    @(negedge clk);
    chk("freeze_cleared", 64'(freeze), 64'd0);
    chk("pend_resp_v", 64'(io_resp_v), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_resp_v", 64'(io_resp_v), 64'd0);
    chk("rst_mid_freeze", 64'(freeze), 64'd1);
    chk("rst_mid_err", 64'(err), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1; io_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_resp_after_rst", 64'(io_resp_v), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
